scene_frame_loader: RTL and testbench



---
 rtl/scene_frame_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_scene_frame_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_frame_loader.sv
// scene_frame_loader
//
// Parses a sync-delimited, XOR-checksummed scene frame (spheres + lights)
// from a UART byte stream. Records are assembled into the shadow bank and
// the shadow bank is made active only when the checksum matches, so
// consumers never observe a partially loaded scene.
//
// Frame: SYNC, nS, nL, nS sphere records, nL light records, CHK
//   CHK = XOR of every byte after SYNC, excluding CHK.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   rxData, rxValid     received byte and its one-cycle qualifier
//   sphereData[i]       active sphere record {cx,cy,cz,radius,R,G,B,refl}
//   lightData[i]        active light record {lx,ly,lz,R,G,B,intensity}
//   numSpheres/Lights   active record counts
//   sceneValid          set from the first commit onward
//   sceneUpdate         one-cycle pulse per commit
//   frameCount          committed frame count, modulo 256
//   errChecksum/errCount/errTimeout  one-cycle error pulses
//   busy                parser is inside a frame
module scene_frame_loader #(
  parameter int         MAX_SPHERES    = 4,
  parameter int         MAX_LIGHTS     = 2,
  parameter int         FIELD_BYTES    = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          rxData,
  input  logic                                rxValid,
  output logic [40*FIELD_BYTES+23:0]          sphereData [0:MAX_SPHERES-1],
  output logic [32*FIELD_BYTES+23:0]          lightData  [0:MAX_LIGHTS-1],
  output logic [$clog2(MAX_SPHERES+1)-1:0]    numSpheres,
  output logic [$clog2(MAX_LIGHTS+1)-1:0]     numLights,
  output logic                                sceneValid,
  output logic                                sceneUpdate,
  output logic [7:0]                          frameCount,
  output logic                                errChecksum,
  output logic                                errCount,
  output logic                                errTimeout,
  output logic                                busy
);

  localparam int FW  = 8 * FIELD_BYTES;
  localparam int SW  = 5 * FW + 24;
  localparam int LW  = 4 * FW + 24;
  localparam int CWS = $clog2(MAX_SPHERES + 1);
  localparam int CWL = $clog2(MAX_LIGHTS + 1);
  localparam int SIW = (MAX_SPHERES > 1) ? $clog2(MAX_SPHERES) : 1;
  localparam int LIW = (MAX_LIGHTS > 1) ? $clog2(MAX_LIGHTS) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0]    SPH_LAST  = 8'(SW / 8 - 1);
  localparam logic [7:0]    LGT_LAST  = 8'(LW / 8 - 1);
  localparam logic [7:0]    MAX_S8    = 8'(MAX_SPHERES);
  localparam logic [7:0]    MAX_L8    = 8'(MAX_LIGHTS);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_HUNT = 3'd0;
  localparam logic [2:0] S_NS   = 3'd1;
  localparam logic [2:0] S_NL   = 3'd2;
  localparam logic [2:0] S_SPH  = 3'd3;
  localparam logic [2:0] S_LGT  = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  logic [2:0]     state_reg;
  logic [7:0]     ns_raw_reg;
  logic [CWS-1:0] ns_reg;
  logic [CWL-1:0] nl_reg;
  logic [CWS-1:0] sidx_reg;
  logic [CWL-1:0] lidx_reg;
  logic [7:0]     rec_cnt_reg;
  logic [SW-9:0]  rec_reg;
  logic [7:0]     xor_reg;
  logic [TW-1:0]  idle_reg;
  logic           bank_sel_reg;

  // Two banks: [bank_sel_reg] is active, the other one is the shadow.
  logic [SW-1:0] sph_bank [0:1][0:MAX_SPHERES-1];
  logic [LW-1:0] lgt_bank [0:1][0:MAX_LIGHTS-1];

  // Record bytes arrive MSB first and the packed record layout matches the
  // wire order, so shifting bytes in from the bottom yields the packed
  // record once the last byte arrives. Lights use the low LW bits.
  logic [SW-1:0] rec_next;
  logic [7:0]    xor_next;
  logic          shadow;

  assign rec_next = {rec_reg, rxData};
  assign xor_next = xor_reg ^ rxData;
  assign shadow   = ~bank_sel_reg;
  assign busy     = (state_reg != S_HUNT);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_SPHERES; gi++) begin : g_sph_out
      assign sphereData[gi] = sph_bank[bank_sel_reg][gi];
    end
    for (gi = 0; gi < MAX_LIGHTS; gi++) begin : g_lgt_out
      assign lightData[gi] = lgt_bank[bank_sel_reg][gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_HUNT;
      ns_raw_reg   <= '0;
      ns_reg       <= '0;
      nl_reg       <= '0;
      sidx_reg     <= '0;
      lidx_reg     <= '0;
      rec_cnt_reg  <= '0;
      rec_reg      <= '0;
      xor_reg      <= '0;
      idle_reg     <= '0;
      bank_sel_reg <= 1'b0;
      numSpheres   <= '0;
      numLights    <= '0;
      sceneValid   <= 1'b0;
      sceneUpdate  <= 1'b0;
      frameCount   <= '0;
      errChecksum  <= 1'b0;
      errCount     <= 1'b0;
      errTimeout   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MAX_SPHERES; i++) sph_bank[b][i] <= '0;
        for (int i = 0; i < MAX_LIGHTS; i++)  lgt_bank[b][i] <= '0;
      end
    end else begin
      sceneUpdate <= 1'b0;
      errChecksum <= 1'b0;
      errCount    <= 1'b0;
      errTimeout  <= 1'b0;

      if (rxValid) begin
        // A byte always wins over an expiring idle counter.
        idle_reg <= '0;
        case (state_reg)
          S_HUNT: begin
            if (rxData == SYNC_BYTE) begin
              xor_reg   <= '0;
              state_reg <= S_NS;
            end
          end
          S_NS: begin
            ns_raw_reg <= rxData;
            xor_reg    <= xor_next;
            state_reg  <= S_NL;
          end
          S_NL: begin
            xor_reg <= xor_next;
            if (ns_raw_reg > MAX_S8 || rxData > MAX_L8) begin
              errCount  <= 1'b1;
              state_reg <= S_HUNT;
            end else begin
              ns_reg      <= ns_raw_reg[CWS-1:0];
              nl_reg      <= rxData[CWL-1:0];
              sidx_reg    <= '0;
              lidx_reg    <= '0;
              rec_cnt_reg <= '0;
              if (ns_raw_reg != 8'd0)  state_reg <= S_SPH;
              else if (rxData != 8'd0) state_reg <= S_LGT;
              else                     state_reg <= S_CHK;
            end
          end
          S_SPH: begin
            xor_reg <= xor_next;
            rec_reg <= rec_next[SW-9:0];
            if (rec_cnt_reg == SPH_LAST) begin
              rec_cnt_reg <= '0;
              sph_bank[shadow][sidx_reg[SIW-1:0]] <= rec_next;
              if (sidx_reg == ns_reg - CWS'(1)) begin
                state_reg <= (nl_reg != '0) ? S_LGT : S_CHK;
              end else begin
                sidx_reg <= sidx_reg + CWS'(1);
              end
            end else begin
              rec_cnt_reg <= rec_cnt_reg + 8'd1;
            end
          end
          S_LGT: begin
            xor_reg <= xor_next;
            rec_reg <= rec_next[SW-9:0];
            if (rec_cnt_reg == LGT_LAST) begin
              rec_cnt_reg <= '0;
              lgt_bank[shadow][lidx_reg[LIW-1:0]] <= rec_next[LW-1:0];
              if (lidx_reg == nl_reg - CWL'(1)) begin
                state_reg <= S_CHK;
              end else begin
                lidx_reg <= lidx_reg + CWL'(1);
              end
            end else begin
              rec_cnt_reg <= rec_cnt_reg + 8'd1;
            end
          end
          S_CHK: begin
            if (rxData == xor_reg) begin
              bank_sel_reg <= shadow;
              numSpheres   <= ns_reg;
              numLights    <= nl_reg;
              sceneValid   <= 1'b1;
              sceneUpdate  <= 1'b1;
              frameCount   <= frameCount + 8'd1;
            end else begin
              errChecksum <= 1'b1;
            end
            state_reg <= S_HUNT;
          end
          default: state_reg <= S_HUNT;
        endcase
      end else if (state_reg != S_HUNT) begin
        // Abandoned shadow contents need no clearing: the next frame
        // overwrites every slot it commits, and slots beyond the count
        // are stale by definition.
        if (idle_reg == IDLE_LAST) begin
          errTimeout <= 1'b1;
          state_reg  <= S_HUNT;
          idle_reg   <= '0;
        end else begin
          idle_reg <= idle_reg + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_scene_frame_loader.sv
// Testbench for scene_frame_loader: directed frames on a default build
// (short timeout) and a FIELD_BYTES=2 build; commit/error events are
// checked against a queue of expected events.
module tb_scene_frame_loader;

  localparam int T = 40;

  localparam logic [3:0] K_UPD = 4'b1000;
  localparam logic [3:0] K_CHK = 4'b0100;
  localparam logic [3:0] K_CNT = 4'b0010;
  localparam logic [3:0] K_TO  = 4'b0001;

  localparam logic [183:0] S1 = {32'h00010000, 32'h00000000, 32'h00050000,
                                 32'h00008000, 24'hFF0000, 32'h00004000};
  localparam logic [151:0] L1 = {32'h000A0000, 32'h000A0000, 32'h000A0000,
                                 24'hFFFFFF, 32'h00010000};
  localparam logic [183:0] S2 = {32'h11223344, 32'h55667788, 32'h99AABBCC,
                                 32'hDDEEFF01, 24'h123456, 32'h0BADF00D};
  localparam logic [183:0] S3 = {32'hFFFFFFFF, 32'h00000001, 32'h80000000,
                                 32'h7FFFFFFF, 24'hA5A5A5, 32'hCAFEBABE};
  localparam logic [151:0] L2 = {32'h01020304, 32'h05060708, 32'h090A0B0C,
                                 24'h0D0E0F, 32'h10111213};
  localparam logic [151:0] L3 = {32'hFEDCBA98, 32'h76543210, 32'h0F0F0F0F,
                                 24'h00FF00, 32'hA5000000};
  localparam logic [103:0] SB16 = {16'h0100, 16'h0000, 16'h0500, 16'h0080,
                                   24'hFF0000, 16'h0040};
  localparam logic [87:0]  LB16 = {16'h0A00, 16'h0A00, 16'h0A00,
                                   24'hFFFFFF, 16'h0100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] rx_a, rx_b;
  logic       val_a, val_b;

  logic [183:0] sph_a [0:3];
  logic [151:0] lgt_a [0:1];
  logic [2:0]   ns_a;
  logic [1:0]   nl_a;
  logic         valid_a, upd_a, echk_a, ecnt_a, eto_a, busy_a;
  logic [7:0]   fc_a;

  logic [103:0] sph_b [0:3];
  logic [87:0]  lgt_b [0:1];
  logic [2:0]   ns_b;
  logic [1:0]   nl_b;
  logic         valid_b, upd_b, echk_b, ecnt_b, eto_b, busy_b;
  logic [7:0]   fc_b;

  scene_frame_loader #(.TIMEOUT_CYCLES(T)) dut_a (
    .clk(clk), .reset(reset), .rxData(rx_a), .rxValid(val_a),
    .sphereData(sph_a), .lightData(lgt_a),
    .numSpheres(ns_a), .numLights(nl_a),
    .sceneValid(valid_a), .sceneUpdate(upd_a), .frameCount(fc_a),
    .errChecksum(echk_a), .errCount(ecnt_a), .errTimeout(eto_a),
    .busy(busy_a)
  );

  scene_frame_loader #(.FIELD_BYTES(2), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .reset(reset), .rxData(rx_b), .rxValid(val_b),
    .sphereData(sph_b), .lightData(lgt_b),
    .numSpheres(ns_b), .numLights(nl_b),
    .sceneValid(valid_b), .sceneUpdate(upd_b), .frameCount(fc_b),
    .errChecksum(echk_b), .errCount(ecnt_b), .errTimeout(eto_b),
    .busy(busy_b)
  );

  typedef struct {
    logic [3:0]   kind;
    logic         chk_rec;
    logic [183:0] s0;
    logic [151:0] l0;
    logic [2:0]   ns;
    logic [1:0]   nl;
    logic [7:0]   fc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fb[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_ev(input logic [3:0] kind, input logic chk_rec,
                           input logic [183:0] s0, input logic [151:0] l0,
                           input logic [2:0] ns, input logic [1:0] nl,
                           input logic [7:0] fc);
    ev_t e;
    e.kind = kind; e.chk_rec = chk_rec; e.s0 = s0; e.l0 = l0;
    e.ns = ns; e.nl = nl; e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Record bytes on the wire are the packed record, MSB byte first.
  task automatic push_rec(input logic [183:0] rec, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) fb.push_back(rec[8*i +: 8]);
  endtask

  task automatic send_q(input int which);
    foreach (fb[i]) begin
      @(negedge clk);
      if (which == 0) begin rx_a = fb[i]; val_a = 1'b1; end
      else            begin rx_b = fb[i]; val_b = 1'b1; end
    end
    @(negedge clk);
    val_a = 1'b0;
    val_b = 1'b0;
    fb.delete();
  endtask

  task automatic send_frame(input int which, input bit corrupt);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < fb.size(); i++) c = c ^ fb[i];
    if (corrupt) c = c ^ 8'h5A;
    fb.push_back(c);
    send_q(which);
  endtask

  // Event monitor for the default build.
  always @(negedge clk) begin : mon
    logic [3:0] k;
    ev_t        e;
    k = {upd_a, echk_a, ecnt_a, eto_a};
    if (k != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", k, 4'b0000);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        if (e.kind == K_UPD) begin
          check("commit_ns", ns_a, e.ns);
          check("commit_nl", nl_a, e.nl);
          check("commit_fc", fc_a, e.fc);
          check("commit_valid", valid_a, 1'b1);
          if (e.chk_rec) begin
            check("commit_sph0", sph_a[0], e.s0);
            check("commit_lgt0", lgt_a[0], e.l0);
          end
        end
        $display("event kind=%b fc=%0d ns=%0d nl=%0d", k, fc_a, ns_a, nl_a);
      end
    end
  end

  initial begin
    reset = 1'b1;
    rx_a = 8'h00; rx_b = 8'h00; val_a = 1'b0; val_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ns", ns_a, 0);
    check("rst_nl", nl_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_upd", upd_a, 0);
    check("rst_fc", fc_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_sph0", sph_a[0], 0);
    check("rst_lgt0", lgt_a[0], 0);

    // Good frame 1/1.
    fb = {8'hA5, 8'h01, 8'h01};
    push_rec(S1, 23); push_rec({32'h0, L1}, 19);
    expect_ev(K_UPD, 1'b1, S1, L1, 3'd1, 2'd1, 8'd1);
    send_frame(0, 1'b0);
    check("good_upd_timing", upd_a, 1);
    check("good_busy", busy_a, 0);
    @(negedge clk);
    check("good_upd_pulse", upd_a, 0);

    // Bad checksum leaves the active scene untouched.
    fb = {8'hA5, 8'h01, 8'h01};
    push_rec(S2, 23); push_rec({32'h0, L2}, 19);
    expect_ev(K_CHK, 1'b0, '0, '0, '0, '0, '0);
    send_frame(0, 1'b1);
    check("badchk_timing", echk_a, 1);
    @(negedge clk);
    check("badchk_sph0", sph_a[0], S1);
    check("badchk_lgt0", lgt_a[0], L1);
    check("badchk_ns", ns_a, 1);
    check("badchk_fc", fc_a, 1);

    // Count error, then a 2/2 frame.
    fb = {8'hA5, 8'h05, 8'h01};
    expect_ev(K_CNT, 1'b0, '0, '0, '0, '0, '0);
    send_q(0);
    check("cnt_timing", ecnt_a, 1);
    check("cnt_busy", busy_a, 0);
    fb = {8'hA5, 8'h02, 8'h02};
    push_rec(S2, 23); push_rec(S3, 23);
    push_rec({32'h0, L2}, 19); push_rec({32'h0, L3}, 19);
    expect_ev(K_UPD, 1'b1, S2, L2, 3'd2, 2'd2, 8'd2);
    send_frame(0, 1'b0);
    check("two_sph1", sph_a[1], S3);
    check("two_lgt1", lgt_a[1], L3);

    // Timeout after the third sphere byte.
    fb = {8'hA5, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00};
    expect_ev(K_TO, 1'b0, '0, '0, '0, '0, '0);
    send_q(0);
    repeat (T - 1) @(negedge clk);
    check("to_early", eto_a, 0);
    check("to_busy_before", busy_a, 1);
    @(negedge clk);
    check("to_pulse", eto_a, 1);
    check("to_busy_after", busy_a, 0);
    fb = {8'hA5, 8'h01, 8'h01};
    push_rec(S1, 23); push_rec({32'h0, L1}, 19);
    expect_ev(K_UPD, 1'b1, S1, L1, 3'd1, 2'd1, 8'd3);
    send_frame(0, 1'b0);

    // Garbage, then an empty frame whose nL byte lands on the expiry cycle.
    fb = {8'h12, 8'h34, 8'hA5, 8'h00};
    send_q(0);
    repeat (T - 2) @(negedge clk);
    fb = {8'h00, 8'h00};
    expect_ev(K_UPD, 1'b0, '0, '0, 3'd0, 2'd0, 8'd4);
    send_q(0);
    check("empty_upd", upd_a, 1);
    check("empty_ns", ns_a, 0);
    check("empty_valid", valid_a, 1);

    // Reset mid-record.
    fb = {8'hA5, 8'h01, 8'h01, 8'h00, 8'h01};
    send_q(0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", valid_a, 0);
    check("midrst_fc", fc_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_sph0", sph_a[0], 0);
    check("midrst_lgt0", lgt_a[0], 0);
    fb = {8'hA5, 8'h01, 8'h01};
    push_rec(S1, 23); push_rec({32'h0, L1}, 19);
    expect_ev(K_UPD, 1'b1, S1, L1, 3'd1, 2'd1, 8'd1);
    send_frame(0, 1'b0);

    // frameCount wrap 255 -> 0.
    for (int i = 2; i <= 256; i++) begin
      fb = {8'hA5, 8'h00, 8'h00};
      expect_ev(K_UPD, 1'b0, '0, '0, 3'd0, 2'd0, 8'(i));
      send_frame(0, 1'b0);
    end
    @(negedge clk);
    check("wrap_fc", fc_a, 0);
    check("wrap_valid", valid_a, 1);

    // 16-bit field build.
    fb = {8'hA5, 8'h01, 8'h01};
    push_rec({80'h0, SB16}, 13); push_rec({96'h0, LB16}, 11);
    send_frame(1, 1'b0);
    check("fb2_upd", upd_b, 1);
    check("fb2_sph0", sph_b[0], SB16);
    check("fb2_lgt0", lgt_b[0], LB16);
    check("fb2_ns", ns_b, 1);
    check("fb2_nl", nl_b, 1);
    check("fb2_fc", fc_b, 1);
    $display("fb2 frame sph0=%h lgt0=%h", sph_b[0], lgt_b[0]);

    repeat (3) @(negedge clk);
    check("events_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
